cache_mem_ctrl: RTL and testbench
=================================

Name: cache_mem_ctrl

Overview:
Memory-side controller directly downstream of the two-way set-associative data cache. It services cache misses by fetching the whole block (WORDS_PER_BLOCK words) from main memory and returning it word by word for the cache to fill. It also absorbs write-through stores in a small write buffer and drains them to memory. A single req/ack port to main memory is shared by refills and stores.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
WORDS_PER_BLOCK, 2, words per cache block (power of 2, ≥2)
WBUF_DEPTH, 4, write-buffer entries (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_req  in  1  cache miss pending; cache holds it high until refill_done
miss_addr  in  ADDR_WIDTH  missing byte address; stable while miss_req high
refill_valid  out  1  one-cycle pulse: refill_data/refill_idx valid
refill_idx  out  log2(WORDS_PER_BLOCK)  word index within the block
refill_data  out  DATA_WIDTH  fetched word
refill_done  out  1  pulses together with the last refill_valid
busy  out  1  high whenever state != IDLE
wr_req  in  1  write-through store request
wr_addr  in  ADDR_WIDTH  store byte address (word aligned)
wr_data  in  DATA_WIDTH  store data
wr_ready  out  1  buffer can accept; push = wr_req & wr_ready
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  memory word address (byte address, bits[1:0]=0)
mem_wdata  out  DATA_WIDTH  write data
mem_ack  in  1  transaction completes in the cycle it is sampled high
mem_rdata  in  DATA_WIDTH  read data, valid in the mem_ack cycle

Behaviour:
- Reset: state=IDLE; FIFO empty; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; refill_valid=0, refill_done=0, refill_idx=0, refill_data=0; busy=0; wr_ready=1. All outputs are registered.
- FSM states: IDLE, DRAIN, RF_REQ, RF_WAIT, WB_WAIT.
- IDLE + miss_req → DRAIN if the FIFO is non-empty, else RF_REQ. Block base = miss_addr with the low log2(WORDS_PER_BLOCK*4) bits cleared; it is latched on exit from IDLE.
- IDLE + !miss_req + FIFO non-empty → WB_WAIT. Drive the head entry on mem_*, with mem_we=1.
- WB_WAIT: hold mem_req/addr/wdata/we stable until mem_ack. On ack, pop the FIFO and go to IDLE. The next transaction may start the cycle after IDLE.
- DRAIN: issue stores back to back (same hold rule) until the FIFO is empty, then go to RF_REQ. Refills never bypass buffered stores (RAW ordering).
- RF_REQ/RF_WAIT: read words idx 0..WORDS_PER_BLOCK-1 in ascending order, mem_addr = base + idx*4. On each ack, the next cycle has refill_valid=1 with the captured idx and data. On the last word, refill_done=1 in that same cycle and the state returns to IDLE.
- wr_ready = (count < WBUF_DEPTH) & (state ∉ {DRAIN, RF_REQ, RF_WAIT}). Stores are blocked while a miss is serviced. count is a registered value, so a pop does not free a slot in the same cycle.
- A push and a pop in the same cycle are allowed (count unchanged). A push when full is impossible by construction. Push/pop pointers wrap modulo WBUF_DEPTH.
- miss_req must not drop before refill_done; behaviour if it does is undefined (assertion).
- Reset mid-transaction: everything returns to the reset state asynchronously and mem_req drops immediately. Buffered stores are lost and the memory model must tolerate the abandoned request.

Optional Feature:
CACHE_MEM_CRIT_WORD_FIRST_EN
- Defined: the refill starts at the critical word idx = miss_addr word-in-block field and wraps modulo WORDS_PER_BLOCK. refill_idx reports the true index; refill_done is asserted on the WORDS_PER_BLOCK-th word.
- Undefined: the refill always starts at idx 0.

Decomposition:
- Package cache_pkg: ADDR_WIDTH/DATA_WIDTH defaults, the block-offset and word-index width constants, the FSM state enum cache_mem_state_t, and a packed wbuf_entry_t {addr, data}.
- Sub-module wbuf_fifo: a parameterised synchronous FIFO of wbuf_entry_t with push, pop, head, count, full and empty. cache_mem_ctrl instantiates it once.

Test Plan:
- Refill, 1-cycle ack latency, miss_addr=0x0000_0104, empty FIFO → mem reads at 0x100 then 0x104; refill_valid idx0 then idx1; refill_done with idx1; busy low afterwards.
- Three stores (0x10=0xA, 0x14=0xB, 0x18=0xC) then miss_req at 0x200 → three mem writes in order, then reads at 0x200/0x204. wr_ready=0 from the miss until refill_done.
- Fill the FIFO with 4 stores while mem_ack is held low → wr_ready=0 at count=4. A fifth wr_req is not accepted. Release ack → drains in FIFO order.
- Variable ack delay (0–5 wait cycles) → mem_addr, mem_we and mem_wdata are stable every cycle while mem_req=1 && !mem_ack.
- rst_n asserted during RF_WAIT → mem_req=0 and all outputs at reset values immediately. A new miss after release starts at idx 0 (or at the critical word).
- With CACHE_MEM_CRIT_WORD_FIRST_EN, miss_addr=0x304 → reads 0x304 then 0x300; refill_idx 1 then 0; refill_done on the second word.

Source files
------------

// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types and default sizing for the cache memory-side controller.
// Optional build macro honoured by cache_mem_ctrl: CACHE_MEM_CRIT_WORD_FIRST_EN.
package cache_pkg;

    localparam int unsigned CACHE_ADDR_WIDTH      = 32;
    localparam int unsigned CACHE_DATA_WIDTH      = 32;
    localparam int unsigned CACHE_WORDS_PER_BLOCK = 2;

    function automatic int unsigned blk_off_w(input int unsigned words_per_block);
        return $clog2(words_per_block * 4);
    endfunction

    function automatic int unsigned word_idx_w(input int unsigned words_per_block);
        return $clog2(words_per_block);
    endfunction

    localparam int unsigned BLK_OFF_W  = blk_off_w(CACHE_WORDS_PER_BLOCK);
    localparam int unsigned WORD_IDX_W = word_idx_w(CACHE_WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RF_REQ,
        RF_WAIT,
        WB_WAIT
    } cache_mem_state_t;

    typedef struct packed {
        logic [CACHE_ADDR_WIDTH-1:0] addr;
        logic [CACHE_DATA_WIDTH-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/cache_mem_ctrl_wbuf_fifo.sv
// Write-through store buffer: synchronous FIFO of wbuf_entry_t with head and
// head+1 lookahead so stores can be drained back to back.
module wbuf_fifo
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wbuf_entry_t              push_entry,
    output wbuf_entry_t              head,
    output wbuf_entry_t              next_head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    wbuf_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately unreset: contents are meaningless once count is cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        rd_ptr_nx = rd_ptr + 1'b1;
        head      = mem[rd_ptr];
        next_head = mem[rd_ptr_nx];
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side controller below the data cache: block refills plus write-buffer drain
// over one req/ack port. Build macro: CACHE_MEM_CRIT_WORD_FIRST_EN (critical word first).
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = CACHE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = CACHE_DATA_WIDTH,
    parameter int unsigned WORDS_PER_BLOCK = CACHE_WORDS_PER_BLOCK,
    parameter int unsigned WBUF_DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                miss_req,
    input  logic [ADDR_WIDTH-1:0]               miss_addr,
    output logic                                refill_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0]  refill_idx,
    output logic [DATA_WIDTH-1:0]               refill_data,
    output logic                                refill_done,
    output logic                                busy,
    input  logic                                wr_req,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic                                wr_ready,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    input  logic                                mem_ack,
    input  logic [DATA_WIDTH-1:0]               mem_rdata
);

    localparam int unsigned BLK_W = blk_off_w(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W = word_idx_w(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH) + 1;

    cache_mem_state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] base_q, base_nx;
    logic [IDX_W-1:0]      idx_q, idx_nx;
    logic [IDX_W-1:0]      cnt_q, cnt_nx;

    logic                  mem_req_nx, mem_we_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_wdata_nx;
    logic                  refill_valid_nx, refill_done_nx;
    logic [IDX_W-1:0]      refill_idx_nx;
    logic [DATA_WIDTH-1:0] refill_data_nx;
    logic                  busy_nx, wr_ready_nx;

    logic                  push, pop;
    wbuf_entry_t           push_entry, head, next_head;
    logic [CNT_W-1:0]      count, count_nx;
    logic                  fifo_full, fifo_empty;
    logic                  unused_miss_lsb;

    wbuf_fifo #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .next_head  (next_head),
        .count      (count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        push            = wr_req & wr_ready;
        push_entry.addr = wr_addr;
        push_entry.data = wr_data;
        unused_miss_lsb = ^miss_addr[BLK_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            refill_valid <= 1'b0;
            refill_done  <= 1'b0;
            refill_idx   <= '0;
            refill_data  <= '0;
            busy         <= 1'b0;
            wr_ready     <= 1'b1;
        end else begin
            state        <= state_nx;
            base_q       <= base_nx;
            idx_q        <= idx_nx;
            cnt_q        <= cnt_nx;
            mem_req      <= mem_req_nx;
            mem_we       <= mem_we_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            refill_valid <= refill_valid_nx;
            refill_done  <= refill_done_nx;
            refill_idx   <= refill_idx_nx;
            refill_data  <= refill_data_nx;
            busy         <= busy_nx;
            wr_ready     <= wr_ready_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        base_nx         = base_q;
        idx_nx          = idx_q;
        cnt_nx          = cnt_q;
        mem_req_nx      = mem_req;
        mem_we_nx       = mem_we;
        mem_addr_nx     = mem_addr;
        mem_wdata_nx    = mem_wdata;
        refill_valid_nx = 1'b0;
        refill_done_nx  = 1'b0;
        refill_idx_nx   = refill_idx;
        refill_data_nx  = refill_data;
        pop             = 1'b0;

        unique case (state)
            IDLE: begin
                if (miss_req) begin
                    base_nx = {miss_addr[ADDR_WIDTH-1:BLK_W], {BLK_W{1'b0}}};
`ifdef CACHE_MEM_CRIT_WORD_FIRST_EN
                    idx_nx  = miss_addr[BLK_W-1:2];
`else
                    idx_nx  = '0;
`endif
                    cnt_nx  = '0;
                    if (!fifo_empty) begin
                        state_nx     = DRAIN;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = 1'b1;
                        mem_addr_nx  = head.addr;
                        mem_wdata_nx = head.data;
                    end else begin
                        state_nx = RF_REQ;
                    end
                end else if (!fifo_empty) begin
                    state_nx     = WB_WAIT;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = head.addr;
                    mem_wdata_nx = head.data;
                end
            end
            WB_WAIT: begin
                if (mem_ack) begin
                    pop        = 1'b1;
                    state_nx   = IDLE;
                    mem_req_nx = 1'b0;
                    mem_we_nx  = 1'b0;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    // Lookahead entry is loaded on the ack edge so stores go out back to back.
                    if (count == CNT_W'(1)) begin
                        state_nx   = RF_REQ;
                        mem_req_nx = 1'b0;
                        mem_we_nx  = 1'b0;
                    end else begin
                        mem_addr_nx  = next_head.addr;
                        mem_wdata_nx = next_head.data;
                    end
                end
            end
            RF_REQ: begin
                state_nx    = RF_WAIT;
                mem_req_nx  = 1'b1;
                mem_we_nx   = 1'b0;
                mem_addr_nx = base_q | ADDR_WIDTH'({idx_q, 2'b00});
            end
            RF_WAIT: begin
                if (mem_ack) begin
                    mem_req_nx      = 1'b0;
                    refill_valid_nx = 1'b1;
                    refill_idx_nx   = idx_q;
                    refill_data_nx  = mem_rdata;
                    idx_nx          = idx_q + 1'b1;
                    cnt_nx          = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        refill_done_nx = 1'b1;
                        state_nx       = IDLE;
                    end else begin
                        state_nx = RF_REQ;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        count_nx    = count + CNT_W'(push) - CNT_W'(pop);
        busy_nx     = (state_nx != IDLE);
        wr_ready_nx = (count_nx < CNT_W'(WBUF_DEPTH)) &&
                      !(state_nx inside {DRAIN, RF_REQ, RF_WAIT});
    end

    a_miss_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state inside {DRAIN, RF_REQ, RF_WAIT}) |-> miss_req);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !fifo_full);

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: directed stores/misses, expected memory
// transactions and refill beats queued at issue time, checked by the memory-model monitor.
`timescale 1ns/1ps
module tb_cache_mem_ctrl;
    import cache_pkg::*;

    localparam int unsigned WPB = CACHE_WORDS_PER_BLOCK;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  miss_req = 1'b0;
    logic [31:0]           miss_addr = '0;
    logic                  refill_valid;
    logic [WORD_IDX_W-1:0] refill_idx;
    logic [31:0]           refill_data;
    logic                  refill_done;
    logic                  busy;
    logic                  wr_req = 1'b0;
    logic [31:0]           wr_addr = '0;
    logic [31:0]           wr_data = '0;
    logic                  wr_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack = 1'b0;
    logic [31:0]           mem_rdata = '0;

    always #5 clk = ~clk;

    cache_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .refill_valid (refill_valid),
        .refill_idx   (refill_idx),
        .refill_data  (refill_data),
        .refill_done  (refill_done),
        .busy         (busy),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        logic [WORD_IDX_W-1:0] idx;
        logic [31:0]           data;
        logic                  done;
    } rf_exp_t;

    mem_exp_t mem_q[$];
    rf_exp_t  rf_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        hold_ack = 1'b0;
    logic        var_delay = 1'b0;
    int unsigned fixed_delay = 1;
    int unsigned txn = 0;
    int unsigned wait_cnt = 0;
    int unsigned delays [6] = '{0, 5, 2, 3, 1, 4};

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Memory model and monitor share one process so ack decisions and checks are ordered.
    initial begin : mem_model
        logic        prev_pend;
        logic [31:0] pa, pd;
        logic        pw;
        int unsigned dly;
        mem_exp_t    me;
        rf_exp_t     re;
        prev_pend = 1'b0;
        pa = '0; pd = '0; pw = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n) begin
                prev_pend = 1'b0;
                wait_cnt  = 0;
                continue;
            end
            if (prev_pend) begin
                check("hold_req",   {31'd0, mem_req}, 32'd1);
                check("hold_addr",  mem_addr, pa);
                check("hold_we",    {31'd0, mem_we}, {31'd0, pw});
                check("hold_wdata", mem_wdata, pd);
            end
            if (refill_done)
                check("done_with_valid", {31'd0, refill_valid}, 32'd1);
            if (refill_valid) begin
                if (rf_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL refill_unexpected: got idx %0d data %h, required none", refill_idx, refill_data);
                end else begin
                    re = rf_q.pop_front();
                    check("refill_idx",  32'(refill_idx), 32'(re.idx));
                    check("refill_data", refill_data, re.data);
                    check("refill_done", {31'd0, refill_done}, {31'd0, re.done});
                end
            end
            if (mem_req && !hold_ack) begin
                dly = var_delay ? delays[txn % 6] : fixed_delay;
                if (wait_cnt >= dly) begin
                    mem_ack   = 1'b1;
                    wait_cnt  = 0;
                    txn++;
                    mem_rdata = mem_we ? 32'h0 : rd_word(mem_addr);
                    if (mem_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL mem_unexpected: got we=%0d addr %h data %h, required none", mem_we, mem_addr, mem_wdata);
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_we",   {31'd0, mem_we}, {31'd0, me.we});
                        check("mem_addr", mem_addr, me.addr);
                        if (me.we) check("mem_wdata", mem_wdata, me.data);
                    end
                end else begin
                    wait_cnt++;
                end
            end
            prev_pend = mem_req && !mem_ack;
            pa = mem_addr; pd = mem_wdata; pw = mem_we;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_mem_req"},      {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"},       {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"},     mem_addr, 32'd0);
        check({tag, "_mem_wdata"},    mem_wdata, 32'd0);
        check({tag, "_refill_valid"}, {31'd0, refill_valid}, 32'd0);
        check({tag, "_refill_done"},  {31'd0, refill_done}, 32'd0);
        check({tag, "_refill_idx"},   32'(refill_idx), 32'd0);
        check({tag, "_refill_data"},  refill_data, 32'd0);
        check({tag, "_busy"},         {31'd0, busy}, 32'd0);
        check({tag, "_wr_ready"},     {31'd0, wr_ready}, 32'd1);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int unsigned guard;
        mem_exp_t    e;
        guard = 0;
        while (!wr_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("store_wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        e = '{1'b1, a, d};
        mem_q.push_back(e);
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input int unsigned first);
        logic [31:0] base;
        int unsigned k, guard;
        logic        blocked, bad, done;
        mem_exp_t    me;
        rf_exp_t     re;
        base = a & ~((32'd1 << BLK_OFF_W) - 32'd1);
        for (int unsigned j = 0; j < WPB; j++) begin
            k  = (first + j) % WPB;
            me = '{1'b0, base + 32'(k * 4), 32'h0};
            re = '{WORD_IDX_W'(k), rd_word(base + 32'(k * 4)), (j == WPB - 1)};
            mem_q.push_back(me);
            rf_q.push_back(re);
        end
        miss_req  = 1'b1;
        miss_addr = a;
        blocked = 1'b0; bad = 1'b0; done = 1'b0; guard = 0;
        while (!done && guard < 500) begin
            @(negedge clk);
            guard++;
            if (refill_done) done = 1'b1;
            else if (!wr_ready) blocked = 1'b1;
            else if (blocked) bad = 1'b1;
        end
        miss_req = 1'b0;
        check("miss_done_seen",      {31'd0, done}, 32'd1);
        check("miss_wr_ready_low",   {31'd0, blocked}, 32'd1);
        check("miss_wr_ready_stays", {31'd0, bad}, 32'd0);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned guard;
        guard = 0;
        while ((busy || mem_req || mem_q.size() != 0 || rf_q.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drain_mem_q"}, 32'(mem_q.size()), 32'd0);
        check({tag, "_drain_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin : stimulus
        int unsigned guard;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic refill with a one-cycle ack wait and an empty buffer
        fixed_delay = 1;
`ifdef CACHE_MEM_CRIT_WORD_FIRST_EN
        do_miss(32'h0000_0104, 1);
`else
        do_miss(32'h0000_0104, 0);
`endif
        @(negedge clk);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Buffered stores must reach memory before the refill reads
        hold_ack = 1'b1;
        do_store(32'h10, 32'hA);
        do_store(32'h14, 32'hB);
        do_store(32'h18, 32'hC);
        hold_ack = 1'b0;
        do_miss(32'h0000_0200, 0);
        wait_drain("t2");

        // Full buffer: fifth store refused until the buffer drains
        hold_ack = 1'b1;
        do_store(32'h20, 32'hD0);
        do_store(32'h24, 32'hD1);
        do_store(32'h28, 32'hD2);
        do_store(32'h2C, 32'hD3);
        check("t3_full_wr_ready", {31'd0, wr_ready}, 32'd0);
        wr_req  = 1'b1;
        wr_addr = 32'h40;
        wr_data = 32'hEEEE;
        repeat (2) @(negedge clk);
        check("t3_full_holds", {31'd0, wr_ready}, 32'd0);
        wr_req   = 1'b0;
        hold_ack = 1'b0;
        wait_drain("t3");
        repeat (3) @(negedge clk);
        check("t3_fifth_rejected", 32'(mem_q.size()), 32'd0);
        check("t3_wr_ready_back",  {31'd0, wr_ready}, 32'd1);

        // Variable ack latency; the monitor checks request stability every cycle
        var_delay = 1'b1;
        txn = 0;
        do_store(32'h50, 32'h1111_0050);
        do_store(32'h54, 32'h1111_0054);
        do_store(32'h58, 32'h1111_0058);
`ifdef CACHE_MEM_CRIT_WORD_FIRST_EN
        do_miss(32'h0000_0608, 0);
        do_miss(32'h0000_070C, 1);
`else
        do_miss(32'h0000_0608, 0);
        do_miss(32'h0000_070C, 0);
`endif
        wait_drain("t4");
        var_delay = 1'b0;

        // Asynchronous reset while a refill read is outstanding
        hold_ack  = 1'b1;
        miss_req  = 1'b1;
        miss_addr = 32'h0000_0404;
        guard = 0;
        while (!mem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("t5_rf_wait_reached", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n    = 1'b0;
        miss_req = 1'b0;
        #1;
        check_reset("t5_async");
        hold_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef CACHE_MEM_CRIT_WORD_FIRST_EN
        do_miss(32'h0000_0404, 1);
`else
        do_miss(32'h0000_0404, 0);
`endif
        wait_drain("t5");

        // Miss on the upper word of a block
`ifdef CACHE_MEM_CRIT_WORD_FIRST_EN
        do_miss(32'h0000_0304, 1);
`else
        do_miss(32'h0000_0304, 0);
`endif
        wait_drain("t6");
        check("final_rf_q", 32'(rf_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

endmodule
